// File: rtl/sdram_arb_pkg.sv
// sdram_arb_pkg: shared types and defaults for the SDRAM port arbiter
package sdram_arb_pkg;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    typedef enum logic [1:0] {G_P0, G_P1, G_P2, G_REF} grant_t;

    localparam int DEBT_W             = 3;
    localparam int DEF_ADDR_W         = 24;
    localparam int DEF_REFRESH_CYCLES = 390;
    localparam int DEF_URGENT_DEBT    = 4;

endpackage

// File: rtl/sdram_refresh_timer.sv
// sdram_refresh_timer: periodic refresh credit generator with saturating debt
module sdram_refresh_timer
    import sdram_arb_pkg::*;
#(
    parameter int REFRESH_CYCLES = DEF_REFRESH_CYCLES,
    parameter int URGENT_DEBT    = DEF_URGENT_DEBT
) (
    input  logic              CLOCK,
    input  logic              RESET_N,
    input  logic              refresh_done,
    output logic [DEBT_W-1:0] debt,
    output logic              urgent
);

    localparam int TW = $clog2(REFRESH_CYCLES);

    logic [TW-1:0] timer;
    logic          wrap;

    assign wrap   = timer == TW'(REFRESH_CYCLES - 1);
    assign urgent = int'(debt) >= URGENT_DEBT;

    // a credit and a completion in the same cycle cancel out
    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            timer <= '0;
            debt  <= '0;
        end else begin
            timer <= wrap ? '0 : timer + 1'b1;
            if (wrap && !refresh_done && debt != '1)
                debt <= debt + 1'b1;
            else if (refresh_done && !wrap && debt != '0)
                debt <= debt - 1'b1;
        end
    end

endmodule

// File: rtl/sdram_port_arbiter.sv
// sdram_port_arbiter: shares one SDRAM command port between three requesters and refresh
module sdram_port_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int ADDR_W         = DEF_ADDR_W,
    parameter int REFRESH_CYCLES = DEF_REFRESH_CYCLES,
    parameter int URGENT_DEBT    = DEF_URGENT_DEBT
) (
    input  logic              CLOCK,
    input  logic              RESET_N,
    input  logic              p0_req,
    input  logic              p0_we,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [15:0]       p0_wdata,
    input  logic [1:0]        p0_be,
    output logic              p0_ack,
    output logic [15:0]       p0_rdata,
    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [15:0]       p1_wdata,
    input  logic [1:0]        p1_be,
    output logic              p1_ack,
    output logic [15:0]       p1_rdata,
    input  logic              p2_req,
    input  logic              p2_we,
    input  logic [ADDR_W-1:0] p2_addr,
    input  logic [15:0]       p2_wdata,
    input  logic [1:0]        p2_be,
    output logic              p2_ack,
    output logic [15:0]       p2_rdata,
    output logic              mem_req,
    output logic              mem_refresh,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_wdata,
    output logic [1:0]        mem_dqm,
    input  logic              mem_ack,
    input  logic [15:0]       mem_rdata
);

    state_t            state_q, state_d;
    grant_t            grant_q, grant_d;
    logic [DEBT_W-1:0] debt;
    logic              urgent;
    logic              rr_p2;
    logic              pending, launch, done_now, refresh_done;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [15:0]       sel_wdata;
    logic [1:0]        sel_be;

    sdram_refresh_timer #(
        .REFRESH_CYCLES(REFRESH_CYCLES),
        .URGENT_DEBT   (URGENT_DEBT)
    ) u_timer (
        .CLOCK       (CLOCK),
        .RESET_N     (RESET_N),
        .refresh_done(refresh_done),
        .debt        (debt),
        .urgent      (urgent)
    );

    assign done_now     = state_q == BUSY && mem_ack;
    assign refresh_done = done_now && grant_q == G_REF;

    // rr_p2 set means p2 wins the next p1/p2 tie
    always_comb begin
        pending = urgent || p0_req || p1_req || p2_req || debt != '0;
        grant_d = urgent ? G_REF :
                  p0_req ? G_P0 :
                  (p1_req && (!p2_req || !rr_p2)) ? G_P1 :
                  p2_req ? G_P2 : G_REF;
        launch  = state_q == IDLE && pending;
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = pending ? BUSY : IDLE;
            BUSY:    state_d = mem_ack ? DONE : BUSY;
            default: state_d = IDLE;
        endcase
    end

    // refresh keeps the previous address/data; they are don't-care downstream
    always_comb begin
        sel_we    = grant_d == G_P0 ? p0_we : grant_d == G_P1 ? p1_we :
                    grant_d == G_P2 ? p2_we : 1'b0;
        sel_addr  = grant_d == G_P0 ? p0_addr : grant_d == G_P1 ? p1_addr :
                    grant_d == G_P2 ? p2_addr : mem_addr;
        sel_wdata = grant_d == G_P0 ? p0_wdata : grant_d == G_P1 ? p1_wdata :
                    grant_d == G_P2 ? p2_wdata : mem_wdata;
        sel_be    = grant_d == G_P0 ? p0_be : grant_d == G_P1 ? p1_be :
                    grant_d == G_P2 ? p2_be : 2'b00;
    end

    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= IDLE;
            grant_q <= G_P0;
        end else begin
            state_q <= state_d;
            if (launch)
                grant_q <= grant_d;
        end
    end

    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            mem_req     <= 1'b0;
            mem_refresh <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            mem_dqm     <= 2'b11;
            rr_p2       <= 1'b0;
        end else if (launch) begin
            mem_req     <= 1'b1;
            mem_refresh <= grant_d == G_REF;
            mem_we      <= sel_we;
            mem_addr    <= sel_addr;
            mem_wdata   <= sel_wdata;
            mem_dqm     <= grant_d == G_REF ? 2'b11 : sel_we ? ~sel_be : 2'b00;
            if (grant_d == G_P1)
                rr_p2 <= 1'b1;
            else if (grant_d == G_P2)
                rr_p2 <= 1'b0;
        end else if (done_now) begin
            mem_req <= 1'b0;
        end
    end

    // acks are high only in DONE; rdata updates only on completed reads
    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            p0_ack   <= 1'b0;
            p1_ack   <= 1'b0;
            p2_ack   <= 1'b0;
            p0_rdata <= '0;
            p1_rdata <= '0;
            p2_rdata <= '0;
        end else begin
            p0_ack <= done_now && grant_q == G_P0;
            p1_ack <= done_now && grant_q == G_P1;
            p2_ack <= done_now && grant_q == G_P2;
            if (done_now && !mem_we && grant_q == G_P0)
                p0_rdata <= mem_rdata;
            if (done_now && !mem_we && grant_q == G_P1)
                p1_rdata <= mem_rdata;
            if (done_now && !mem_we && grant_q == G_P2)
                p2_rdata <= mem_rdata;
        end
    end

endmodule
